aes_job_arbiter: RTL
====================

# aes_job_arbiter

Round-robin arbiter and sequencer that shares one AES decryption core between `NUM_REQ` requesters, such as multiple Avalon-MM register front-ends or DMA channels.
- Accepts one job at a time and latches its 128-bit key and ciphertext.
- Drives the core's level-sensitive start/done handshake.
- Returns the plaintext on a shared response bus, tagged with the requester ID.
- Sits between the requester interfaces and the AES core instance, and owns the core's START, KEY and MSG_ENC inputs.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters (2–8); `IDW = $clog2(NUM_REQ)`.
- `TIMEOUT`, default 1023: RUN-state watchdog limit in cycles; used only with `AES_ARB_TIMEOUT_EN`.

Ports:
- `CLK` in 1: the single clock.
- `RESET` in 1: asynchronous, active-high reset.
- `REQ` in `NUM_REQ`: per-requester job request, level.
- `REQ_KEY` in `NUM_REQ*128`: key of requester i at `[i*128 +: 128]`.
- `REQ_MSG` in `NUM_REQ*128`: ciphertext of requester i at `[i*128 +: 128]`.
- `ACK` out `NUM_REQ`: one-cycle pulse when requester i's job is latched.
- `RSP_VALID` out 1: one-cycle pulse when the job completes.
- `RSP_ID` out `IDW`: requester that owns the response.
- `RSP_MSG` out 128: decrypted message.
- `RSP_ERR` out 1: job aborted by the watchdog.
- `BUSY` out 1: high in any state other than IDLE.
- `AES_START` out 1: to the core, level.
- `AES_KEY` out 128: to the core.
- `AES_MSG_ENC` out 128: to the core.
- `AES_DONE` in 1: from the core.
- `AES_MSG_DEC` in 128: from the core.

## Operation
- **States:** IDLE, RUN, RELEASE.
- **IDLE:**
  - If any `REQ` bit is high, grant the first set bit searching upward from `last+1` (mod `NUM_REQ`).
  - Latch that requester's `REQ_KEY` and `REQ_MSG` into the `AES_KEY` and `AES_MSG_ENC` registers.
  - Set `cur_id` and `last` to the granted index.
  - Pulse `ACK[id]`, set `AES_START=1`, and go to RUN.
- **RUN:**
  - `AES_START` is held high and the key and message registers are stable.
  - When `AES_DONE` is sampled 1:
    - capture `AES_MSG_DEC` into `RSP_MSG` and set `RSP_ID=cur_id`;
    - pulse `RSP_VALID` and set `RSP_ERR=0`;
    - drop `AES_START` and go to RELEASE.
- **RELEASE:** wait until `AES_DONE` is sampled 0, then go to IDLE. This guarantees the core is idle before the next START.
- **Requester obligations:**
  - Hold `REQ`, `REQ_KEY` and `REQ_MSG` stable until `ACK`.
  - Deassert `REQ` on the cycle after `ACK`, unless queueing another job.
  - A `REQ` still high in the next IDLE is treated as a new job.
  - Withdrawing `REQ` before `ACK` is legal; no response is produced.
- **Response hold:** `RSP_MSG`, `RSP_ID` and `RSP_ERR` hold their values until the next completion.
- **Reset values:** all outputs 0; `last = NUM_REQ-1`, so requester 0 has first priority; state IDLE.
- **Reset mid-job:** the job is discarded, with no `RSP_VALID` and no `ACK` replay. The core shares `RESET`.
- **Simultaneous events:**
  - `REQ` arriving in RUN or RELEASE waits until IDLE.
  - `ACK` and `RSP_VALID` are never high in the same cycle.
  - A single requester's back-to-back jobs are granted when no other requester is pending.

## Timing
- All outputs are registered.
- If `REQ[i]` is sampled in IDLE at edge t, then at edge t+1 `ACK[i]=1`, `AES_START=1`, `BUSY=1`, and the key and message are valid.
- If `AES_DONE` is sampled at edge d, then at edge d+1 `RSP_VALID=1`, `RSP_MSG` is valid and `AES_START=0`.
- If `AES_DONE` is sampled low at edge r, the state is IDLE at r+1 (`BUSY=0`), and the earliest next grant is at r+2.
- Arbiter overhead is 3 cycles per job plus the core latency.
- `AES_START` is never low while in RUN and never high in RELEASE or IDLE.

## Configuration
- **`AES_ARB_TIMEOUT_EN` defined:**
  - A counter clears on entry to RUN and increments each RUN cycle without `AES_DONE`.
  - When the counter reaches `TIMEOUT`, the block pulses `RSP_VALID` with `RSP_ERR=1` and `RSP_MSG=0`, drops `AES_START`, and goes to RELEASE.
  - If `AES_DONE` and the limit occur in the same cycle, DONE wins and the response is normal.
- **`AES_ARB_TIMEOUT_EN` undefined:**
  - No counter is built and `RSP_ERR` is tied to 0.
  - RUN waits for `AES_DONE` indefinitely.

## Test plan
- **Single job:**
  - Stimulus: `REQ=01`, key `000102…0F`, message `DAEC3055DF058E1C39E814EA76F6747E`; core model with 10-cycle latency.
  - Response: `ACK=01` one cycle after the request; `RSP_VALID` with `RSP_ID=0` and `RSP_MSG` equal to the model output; `BUSY` returns to 0.
- **Contention:**
  - Stimulus: `REQ=11` held continuously for 4 jobs.
  - Response: grant order 0,1,0,1; `ACK` and `RSP_VALID` never coincide.
- **Withdraw while busy:**
  - Stimulus: `REQ[1]` raised during requester 0's RUN, then dropped before IDLE.
  - Response: no `ACK[1]` and no response for ID 1.
- **Reset mid-RUN:**
  - Stimulus: `RESET` asserted asynchronously during RUN.
  - Response: all outputs 0 immediately, no `RSP_VALID`; after release, `REQ=10` is granted to requester 1 (RR pointer reset).
- **Watchdog (`AES_ARB_TIMEOUT_EN`, `TIMEOUT=20`):**
  - Stimulus: core never asserts DONE.
  - Response: `RSP_VALID` with `RSP_ERR=1` and `RSP_MSG=0` twenty-one cycles after `ACK`.
- **Watchdog disabled:**
  - Stimulus: same stalled core without the macro.
  - Response: `BUSY` stays 1 and no response is produced.

Source files
------------

// File: rtl/aes_job_arbiter.sv
// aes_job_arbiter: round-robin sequencer sharing one AES decryption core between NUM_REQ requesters.
// Define AES_ARB_TIMEOUT_EN to build the RUN-state watchdog (limit TIMEOUT cycles, aborts with RSP_ERR).
module aes_job_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1023,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NUM_REQ-1:0]     REQ,
  input  logic [NUM_REQ*128-1:0] REQ_KEY,
  input  logic [NUM_REQ*128-1:0] REQ_MSG,
  output logic [NUM_REQ-1:0]     ACK,
  output logic                   RSP_VALID,
  output logic [IDW-1:0]         RSP_ID,
  output logic [127:0]           RSP_MSG,
  output logic                   RSP_ERR,
  output logic                   BUSY,
  output logic                   AES_START,
  output logic [127:0]           AES_KEY,
  output logic [127:0]           AES_MSG_ENC,
  input  logic                   AES_DONE,
  input  logic [127:0]           AES_MSG_DEC
);
  typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;
  state_t         r_state;
  logic [IDW-1:0] r_last;
  logic           w_any;
  logic [IDW-1:0] w_id;
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("aes_job_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
  end
`ifdef AES_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
`else
  assign RSP_ERR = 1'b0;
`endif
  // Scan downward so the requester closest after r_last overwrites the others.
  always_comb begin
    w_any = 1'b0;
    w_id  = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (REQ[(int'(r_last) + k) % NUM_REQ]) begin
        w_any = 1'b1;
        w_id  = IDW'((int'(r_last) + k) % NUM_REQ);
      end
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      r_state     <= IDLE;
      r_last      <= IDW'(NUM_REQ - 1);
      ACK         <= '0;
      RSP_VALID   <= 1'b0;
      RSP_ID      <= '0;
      RSP_MSG     <= '0;
      BUSY        <= 1'b0;
      AES_START   <= 1'b0;
      AES_KEY     <= '0;
      AES_MSG_ENC <= '0;
`ifdef AES_ARB_TIMEOUT_EN
      RSP_ERR     <= 1'b0;
      r_cnt       <= '0;
`endif
    end else begin
      ACK       <= '0;
      RSP_VALID <= 1'b0;
      case (r_state)
        IDLE: if (w_any) begin
          r_state     <= RUN;
          r_last      <= w_id;
          ACK         <= NUM_REQ'(1) << w_id;
          AES_START   <= 1'b1;
          BUSY        <= 1'b1;
          AES_KEY     <= REQ_KEY[w_id*128 +: 128];
          AES_MSG_ENC <= REQ_MSG[w_id*128 +: 128];
`ifdef AES_ARB_TIMEOUT_EN
          r_cnt       <= '0;
`endif
        end
        RUN: if (AES_DONE) begin
          r_state   <= RELEASE;
          RSP_MSG   <= AES_MSG_DEC;
          RSP_ID    <= r_last;
          RSP_VALID <= 1'b1;
          AES_START <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
          RSP_ERR   <= 1'b0;
        end else if (r_cnt == CW'(TIMEOUT)) begin
          r_state   <= RELEASE;
          RSP_MSG   <= '0;
          RSP_ID    <= r_last;
          RSP_VALID <= 1'b1;
          RSP_ERR   <= 1'b1;
          AES_START <= 1'b0;
        end else begin
          r_cnt     <= r_cnt + 1'b1;
`endif
        end
        RELEASE: if (!AES_DONE) begin
          r_state <= IDLE;
          BUSY    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule
